// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Ports: txclk/reset; enable; req_valid/req_data/req_last in, req_ready out;
// ld_tx_data/tx_data/tx_enable to the UART, tx_empty from it; busy, grant_id,
// locked and err_timeout status outputs.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GID_W         = 2,
  parameter int START_TIMEOUT = 15
) (
  input  logic                 txclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 ld_tx_data,
  output logic [7:0]           tx_data,
  output logic                 tx_enable,
  input  logic                 tx_empty,
  output logic                 busy,
  output logic [GID_W-1:0]     grant_id,
  output logic                 locked,
  output logic                 err_timeout
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [GID_W:0] NREQ_X = (GID_W + 1)'(NUM_REQ);
  localparam logic [GID_W-1:0] LAST_ID = GID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t state_q, state_d;

  logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]   grant_id_q, grant_id_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               locked_q, locked_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ld_q, ld_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               err_q, err_d;
  logic               tx_en_q;

  logic               win_found;
  logic [GID_W-1:0]   win_id;
  logic [GID_W:0]     idx_x;
  logic [7:0]         win_data;
  logic               win_last;

  // Scan downwards so the candidate closest to rr_ptr is written last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx_x     = '0;
    if (locked_q) begin
      win_found = req_valid[grant_id_q];
      win_id    = grant_id_q;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx_x = {1'b0, rr_ptr_q} + (GID_W + 1)'(k);
        if (idx_x >= NREQ_X) begin
          idx_x = idx_x - NREQ_X;
        end
        if (req_valid[idx_x[GID_W-1:0]]) begin
          win_found = 1'b1;
          win_id    = idx_x[GID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    win_data = 8'h00;
    win_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == GID_W'(i)) begin
        win_data = req_data[8*i +: 8];
        win_last = req_last[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    locked_d   = locked_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    ld_d       = 1'b0;
    ready_d    = '0;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && tx_empty && win_found) begin
          state_d    = S_LOAD;
          tx_data_d  = win_data;
          grant_id_d = win_id;
          last_d     = win_last;
          ld_d       = 1'b1;
          ready_d    = NUM_REQ'(1) << win_id;
        end
      end
      S_LOAD: begin
        locked_d = ~last_q;
        if (last_q) begin
          rr_ptr_d = (grant_id_q == LAST_ID) ? '0
                   : grant_id_q + 1'b1;
        end
        cnt_d   = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!tx_empty) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (tx_empty) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_data_q  <= 8'h00;
      locked_q   <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      ld_q       <= 1'b0;
      ready_q    <= '0;
      err_q      <= 1'b0;
      tx_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      locked_q   <= locked_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      ld_q       <= ld_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      tx_en_q    <= enable;
    end
  end

  assign req_ready   = ready_q;
  assign ld_tx_data  = ld_q;
  assign tx_data     = tx_data_q;
  assign tx_enable   = tx_en_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = grant_id_q;
  assign locked      = locked_q;
  assign err_timeout = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among NUM_REQ byte producers. It sequences the transmitter's load interface (ld_tx_data, tx_data, tx_enable) and paces loads using tx_empty. Optional frame locking keeps multi-byte messages contiguous. It sits between the requesters and the uart instance, in the transmit clock domain.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- GID_W, 2: width of grant_id, must equal clog2(NUM_REQ)
- START_TIMEOUT, 15: maximum cycles to wait for tx_empty to fall after a load
- txclk  in  1  clock; the only clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  permits new arbitration; registered onto tx_enable
- req_valid  in  NUM_REQ  requester i has a byte pending
- req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i]
- req_last  in  NUM_REQ  pending byte ends requester i's frame
- req_ready  out  NUM_REQ  one-cycle accept pulse to requester i
- ld_tx_data  out  1  one-cycle load strobe to the UART
- tx_data  out  8  byte presented to the UART
- tx_enable  out  1  UART transmit enable
- tx_empty  in  1  UART transmit-holding-register empty
- busy  out  1  high in every state except IDLE
- grant_id  out  GID_W  index of the last granted requester
- locked  out  1  frame lock held by grant_id
- err_timeout  out  1  one-cycle pulse when START_TIMEOUT expires

## Operation
- FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE.
- IDLE: arbitration is eligible when enable=1, tx_empty=1, and at least one requester is eligible. The winner w is the first valid index at or after rr_ptr, wrapping modulo NUM_REQ. When locked=1, only grant_id is eligible, and the arbiter waits indefinitely for it.
  - On win: tx_data<=req_data[w], grant_id<=w, ld_tx_data<=1, req_ready[w]<=1, go to LOAD.
- LOAD: ld_tx_data and req_ready[w] are high for exactly this one cycle, and the transfer completes here.
  - locked<=~req_last[w].
  - If req_last[w]=1, rr_ptr<=(w+1) mod NUM_REQ; otherwise rr_ptr is unchanged.
  - Go to WAIT_START.
- WAIT_START: wait for tx_empty=0, then go to WAIT_DONE. If START_TIMEOUT cycles elapse first, pulse err_timeout, clear locked, and go to IDLE.
- WAIT_DONE: wait for tx_empty=1, then go to IDLE.
- Requester rule: req_valid, req_data and req_last stay stable from the assertion of valid until the cycle after req_ready. The arbiter samples data at the IDLE decision edge.
- If enable drops mid-byte, the in-flight byte completes, but no new grant is issued. tx_enable follows enable with one cycle of delay.
- A lock persists across enable=0. It is released only by a byte with req_last=1, by a timeout, or by reset.
- Reset, including mid-operation, forces the following in the next cycle: state IDLE, rr_ptr=0, and all outputs 0. The UART is reset by the same reset.

## Timing
- Decision edge at the end of IDLE cycle N. ld_tx_data and req_ready pulse in cycle N+1. tx_empty is expected low by cycle N+2.
- Minimum byte period is 3 cycles plus the UART serialization time. The next grant can be decided in the first cycle that tx_empty=1 after WAIT_DONE is exited to IDLE.
- req_ready is never high for more than one cycle, and never for two requesters at once.
- Reset values: ld_tx_data=0, tx_data=8'h00, tx_enable=0, req_ready=0, busy=0, grant_id=0, locked=0, err_timeout=0.

## Test plan
- Single byte: enable=1; requester 2 presents 8'hA5 with last=1 → one ld_tx_data pulse with tx_data=A5, req_ready=4'b0100 in the same cycle, grant_id=2, rr_ptr=3, and tx_out carries A5.
- Fairness: all four requesters present continuous single-byte frames 8'h10..8'h13 → grant order 0,1,2,3,0, with no requester granted twice before the others are served.
- Lock: requester 1 sends 3 bytes (last on the 3rd) while requester 0 stays valid → bytes 1,1,1 go out contiguously with locked=1 during the frame, then requester 0 is granted.
- Stall: hold tx_empty=1 after a load → err_timeout pulses exactly START_TIMEOUT cycles after WAIT_START entry, locked=0, and the FSM returns to IDLE.
- Enable gating: drop enable during WAIT_DONE → the current byte finishes, no further ld_tx_data occurs, tx_enable=0 one cycle later, and raising enable resumes from the correct rr_ptr.
- Reset mid-byte: assert reset in WAIT_DONE → the next cycle shows all outputs 0 and busy=0, and a fresh request after reset is granted starting from index 0.
